// File: rtl/sig_tx_framer_pkg.sv
// Shared definitions for the optical-link TX framer: state encodings, SFD byte, and a sizing helper.
// The receiver imports the same package so both ends agree on the start-of-frame delimiter.
package sig_tx_framer_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_SFD      = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;

    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam int         SFD_BITS = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sig_tx_baud.sv
// Line-bit timer: reloads to CLKS_PER_BIT-1 on restart or on each tick; tick fires when the count is zero.
// With CLKS_PER_BIT=1 the counter sits at zero and o_tick is high every cycle.
module sig_tx_baud
    import sig_tx_framer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_restart,
    output logic o_tick
);

    localparam int                CNT_W  = max_int(1, $clog2(CLKS_PER_BIT + 1));
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_cnt <= RELOAD;
        end else if (i_restart || o_tick) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/sig_tx_framer.sv
// Serialises framed bytes onto the laser drive line: preamble, SFD, payload MSB first, then an idle gap.
// A single-entry hold register decouples the AXI-side handshake from the bit shifter.
module sig_tx_framer
    import sig_tx_framer_pkg::*;
#(
    parameter int   DATA_W       = 8,
    parameter int   CLKS_PER_BIT = 1,
    parameter int   PREAMBLE_LEN = 16,
    parameter int   GAP_BITS     = 8,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input  logic              AXI_clk,
    input  logic              AXI_rstn,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              sig_out,
    output logic              busy,
    output logic              underrun
);

    localparam int BC_MAX = max_int(max_int(PREAMBLE_LEN, GAP_BITS), max_int(DATA_W, SFD_BITS));
    localparam int BC_W   = $clog2(BC_MAX + 1);

    logic [2:0]        r_state;
    logic [BC_W-1:0]   r_bit_cnt;
    logic              r_sig_out;
    logic              r_underrun;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_hold_last;
    logic [DATA_W-1:0] r_shift;
    logic              r_cur_last;
    logic [7:0]        r_sfd;

    logic w_tick;
    logic w_tx_ready;
    logic w_load;
    logic w_drain;
    logic w_pre_end;
    logic w_sfd_end;
    logic w_word_end;
    logic w_gap_end;

    sig_tx_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk    (AXI_clk),
        .i_rstn   (AXI_rstn),
        .i_restart(r_state == ST_IDLE),
        .o_tick   (w_tick)
    );

    // Ready is forced low while reset is held, not just after the hold register clears.
    assign w_tx_ready = AXI_rstn & ~r_hold_full;
    assign w_load     = tx_valid & w_tx_ready;

    assign w_pre_end  = (r_bit_cnt == BC_W'(PREAMBLE_LEN));
    assign w_sfd_end  = (r_bit_cnt == BC_W'(SFD_BITS));
    assign w_word_end = (r_bit_cnt == BC_W'(DATA_W));
    assign w_gap_end  = (r_bit_cnt == BC_W'(GAP_BITS));

    assign w_drain = w_tick & (((r_state == ST_SFD) & w_sfd_end) |
                               ((r_state == ST_DATA) & w_word_end & ~r_cur_last & r_hold_full));

    assign tx_ready = w_tx_ready;
    assign sig_out  = r_sig_out;
    assign busy     = (r_state != ST_IDLE);
    assign underrun = r_underrun;

    always_ff @(posedge AXI_clk) begin
        if (!AXI_rstn) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_sig_out   <= IDLE_LEVEL;
            r_underrun  <= 1'b0;
            r_hold_full <= 1'b0;
        end else begin
            r_underrun  <= 1'b0;
            r_hold_full <= w_load | (r_hold_full & ~w_drain);
            case (r_state)
                ST_IDLE: begin
                    r_sig_out <= IDLE_LEVEL;
                    if (r_hold_full) begin
                        r_state   <= ST_PREAMBLE;
                        r_sig_out <= 1'b1;
                        r_bit_cnt <= BC_W'(1);
                    end
                end
                ST_PREAMBLE: if (w_tick) begin
                    if (w_pre_end) begin
                        r_state   <= ST_SFD;
                        r_sig_out <= SFD_BYTE[7];
                        r_bit_cnt <= BC_W'(1);
                    end else begin
                        r_sig_out <= ~r_sig_out;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_SFD: if (w_tick) begin
                    if (w_sfd_end) begin
                        r_state   <= ST_DATA;
                        r_sig_out <= r_hold_data[DATA_W-1];
                        r_bit_cnt <= BC_W'(1);
                    end else begin
                        r_sig_out <= r_sfd[7];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_DATA: if (w_tick) begin
                    if (!w_word_end) begin
                        r_sig_out <= r_shift[DATA_W-1];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end else if (w_drain) begin
                        r_sig_out <= r_hold_data[DATA_W-1];
                        r_bit_cnt <= BC_W'(1);
                    end else begin
                        // Either a clean end of frame or an abort because no next word was waiting.
                        r_state    <= ST_GAP;
                        r_sig_out  <= IDLE_LEVEL;
                        r_bit_cnt  <= BC_W'(1);
                        r_underrun <= ~r_cur_last;
                    end
                end
                ST_GAP: begin
                    r_sig_out <= IDLE_LEVEL;
                    if (w_tick) begin
                        if (w_gap_end) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_sig_out <= IDLE_LEVEL;
                end
            endcase
        end
    end

    // NOTE: datapath registers are not reset; they are only read after the control path has loaded them.
    always_ff @(posedge AXI_clk) begin
        if (w_load) begin
            r_hold_data <= tx_data;
            r_hold_last <= tx_last;
        end
        if (w_drain) begin
            r_shift    <= r_hold_data << 1;
            r_cur_last <= r_hold_last;
        end else if (w_tick && r_state == ST_DATA) begin
            r_shift <= r_shift << 1;
        end
        if (w_tick && r_state == ST_PREAMBLE && w_pre_end) begin
            r_sfd <= SFD_BYTE << 1;
        end else if (w_tick && r_state == ST_SFD) begin
            r_sfd <= r_sfd << 1;
        end
    end

endmodule

// File: tb/tb_sig_tx_framer.sv
// Directed bench for sig_tx_framer: per-cycle vector table on a CLKS_PER_BIT=1 instance,
// plus a hand-written bit-stretch sequence on a CLKS_PER_BIT=3 instance.
module tb_sig_tx_framer;

    typedef struct {
        int         tid;
        logic       rstn;
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       exp_sig;
        logic       exp_busy;
        logic       exp_ready;
        logic       exp_under;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic       clk = 1'b0;
    logic       rstn;
    logic       valid, last, ready, sig, busy, under;
    logic [7:0] data;
    logic       valid3, last3, ready3, sig3, busy3, under3;
    logic [7:0] data3;

    always #5 clk = ~clk;

    sig_tx_framer #(
        .DATA_W(8), .CLKS_PER_BIT(1), .PREAMBLE_LEN(4), .GAP_BITS(2), .IDLE_LEVEL(1'b0)
    ) dut (
        .AXI_clk(clk), .AXI_rstn(rstn), .tx_data(data), .tx_valid(valid), .tx_last(last),
        .tx_ready(ready), .sig_out(sig), .busy(busy), .underrun(under)
    );

    sig_tx_framer #(
        .DATA_W(8), .CLKS_PER_BIT(3), .PREAMBLE_LEN(4), .GAP_BITS(2), .IDLE_LEVEL(1'b0)
    ) dut3 (
        .AXI_clk(clk), .AXI_rstn(rstn), .tx_data(data3), .tx_valid(valid3), .tx_last(last3),
        .tx_ready(ready3), .sig_out(sig3), .busy(busy3), .underrun(under3)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic void add(input int tid, input logic r, input logic v, input logic [7:0] d,
                                input logic l, input logic s, input logic b, input logic rd,
                                input logic u);
        vecs.push_back('{tid, r, v, d, l, s, b, rd, u});
    endfunction

    // Gap of two line bits then two idle cycles, hold empty throughout.
    function automatic void add_tail(input int tid);
        add(tid, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(tid, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(tid, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(tid, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    // Preamble+SFD+one byte, one line bit per vector; hold drains at the 13th edge.
    function automatic void add_frame(input int tid, input logic [19:0] f);
        for (int i = 0; i < 20; i++)
            add(tid, 1'b1, 1'b0, 8'h00, 1'b0, f[19-i], 1'b1, (i >= 12), 1'b0);
    endfunction

    initial begin
        logic [19:0] f;
        logic [27:0] f2;
        logic [19:0] f4;
        int          e;

        // Test 1: single byte A5, last=1
        add(1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        f = {4'b1010, 8'b11010101, 8'b10100101};
        add_frame(1, f);
        add_tail(1);

        // Test 2: 3C then C3 offered while 3C shifts; no bubble, ready low while hold is full
        add(2, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        f2 = {4'b1010, 8'b11010101, 8'b00111100, 8'b11000011};
        for (int i = 0; i < 28; i++) begin
            e = i + 1;
            add(2, 1'b1, (i == 13), (i == 13) ? 8'hC3 : 8'h00, (i == 13), f2[27-i], 1'b1,
                (e == 13) || (e >= 21), 1'b0);
        end
        add_tail(2);

        // Test 3: 0F with last=0 and nothing following -> underrun pulse entering GAP
        add(3, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        f = {4'b1010, 8'b11010101, 8'b00001111};
        add_frame(3, f);
        add(3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        add(3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Test 5: reset for one cycle in the middle of SFD, then a fresh frame
        add(5, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        f = {4'b1010, 8'b11010101, 8'b10101010};
        for (int i = 0; i < 7; i++)
            add(5, 1'b1, 1'b0, 8'h00, 1'b0, f[19-i], 1'b1, 1'b0, 1'b0);
        add(5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(5, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        f = {4'b1010, 8'b11010101, 8'b01100110};
        add_frame(5, f);
        add_tail(5);

        // Test 6: second frame's word offered during the first frame's GAP -> GAP_BITS+1 idle cycles
        add(6, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        f = {4'b1010, 8'b11010101, 8'b01011010};
        add_frame(6, f);
        add(6, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(6, 1'b1, 1'b1, 8'h96, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(6, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        f = {4'b1010, 8'b11010101, 8'b10010110};
        add_frame(6, f);
        add_tail(6);

        rstn   = 1'b0;
        valid  = 1'b0;
        data   = 8'h00;
        last   = 1'b0;
        valid3 = 1'b0;
        data3  = 8'h00;
        last3  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset sig", sig, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset ready", ready, 1'b0);
        check("reset underrun", under, 1'b0);
        check("reset sig cpb3", sig3, 1'b0);
        check("reset busy cpb3", busy3, 1'b0);
        check("reset ready cpb3", ready3, 1'b0);

        foreach (vecs[i]) begin
            rstn  = vecs[i].rstn;
            valid = vecs[i].valid;
            data  = vecs[i].data;
            last  = vecs[i].last;
            @(posedge clk);
            #1;
            check($sformatf("t%0d v%0d sig_out", vecs[i].tid, i), sig, vecs[i].exp_sig);
            check($sformatf("t%0d v%0d busy", vecs[i].tid, i), busy, vecs[i].exp_busy);
            check($sformatf("t%0d v%0d tx_ready", vecs[i].tid, i), ready, vecs[i].exp_ready);
            check($sformatf("t%0d v%0d underrun", vecs[i].tid, i), under, vecs[i].exp_under);
        end

        // Test 4: CLKS_PER_BIT=3, byte 81 -> each bit held 3 cycles, 60 frame cycles + 6 gap cycles
        f4     = {4'b1010, 8'b11010101, 8'b10000001};
        valid3 = 1'b1;
        data3  = 8'h81;
        last3  = 1'b1;
        @(posedge clk);
        #1;
        check("t4 accept ready", ready3, 1'b0);
        check("t4 accept busy", busy3, 1'b0);
        valid3 = 1'b0;
        for (int c = 0; c < 66; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("t4 c%0d sig_out", c), sig3, (c < 60) ? f4[19 - c / 3] : 1'b0);
            check($sformatf("t4 c%0d busy", c), busy3, 1'b1);
            check($sformatf("t4 c%0d underrun", c), under3, 1'b0);
        end
        @(posedge clk);
        #1;
        check("t4 end busy", busy3, 1'b0);
        check("t4 end ready", ready3, 1'b1);
        check("t4 end sig_out", sig3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
